seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the board's multiplexed 8-digit seven-segment driver.
- Samples the scanned seg_cs_pin/seg_data_pin bus and reconstructs the 32-bit hex value being displayed, plus decimal-point, blank and error flags.
- Used in simulation top-levels and on-chip loopback to check CPU display output (PC, registers, Flag) without visual inspection.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_char_decode.sv | 24 ++
 rtl/seg_scan_decoder.sv | 186 ++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
package seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high gfedcba patterns for hex characters 0..F, indexed by value
  localparam logic [6:0] HEX_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg_char_decode.sv
// Combinational seven-segment to hex decoder; all-off reads as blank,
// any unrecognised pattern reads as an error with nibble 0.
module seg_char_decode
  import seg_pkg::*;
(
  input  logic [6:0] segs,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    blank  = (segs == 7'h00);
    err    = (segs != 7'h00);
    for (int i = 0; i < 16; i++) begin
      if (segs == HEX_PAT[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs the hex value shown on a multiplexed seven-segment display
// by sampling each digit after its select has settled.
//
// state  | meaning
// IDLE   | no valid single-digit select present
// SETTLE | valid select seen, counting stable cycles before sampling
// HOLD   | digit captured, waiting for the select to move on
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    CLK100MHZ,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   seg_cs_pin,
  input  logic [7:0]              seg_data_pin,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    frame_valid,
  output logic                    stale
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  logic [NUM_DIGITS-1:0]   cs_s1, cs_s2;
  logic [7:0]              data_s1, data_s2;
  logic [NUM_DIGITS-1:0]   act;
  logic                    sel_valid;
  logic [IDX_W-1:0]        sel_idx, cur_idx, idx_nxt;
  state_t                  state, state_nxt;
  logic [SET_W-1:0]        settle_cnt, cnt_nxt;
  logic                    capture;
  logic [6:0]              seg_on;
  logic [3:0]              ch_nib;
  logic                    ch_blank, ch_err;
  logic [4*NUM_DIGITS-1:0] sh_dig, sh_dig_nxt;
  logic [NUM_DIGITS-1:0]   sh_dp, sh_dp_nxt, sh_blank, sh_blank_nxt;
  logic [NUM_DIGITS-1:0]   sh_err, sh_err_nxt, seen, seen_nxt;
  logic [TO_W-1:0]         to_cnt, to_cnt_nxt;

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      cs_s1   <= '1;
      cs_s2   <= '1;
      data_s1 <= '1;
      data_s2 <= '1;
    end else begin
      cs_s1   <= seg_cs_pin;
      cs_s2   <= cs_s1;
      data_s1 <= seg_data_pin;
      data_s2 <= data_s1;
    end
  end

  // Valid select means exactly one low bit: act is one-hot
  always_comb begin
    act       = ~cs_s2;
    sel_valid = (act != '0) && ((act & (act - NUM_DIGITS'(1))) == '0);
    sel_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (act[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = settle_cnt;
    idx_nxt   = cur_idx;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
          idx_nxt   = sel_idx;
        end
      end
      SETTLE: begin
        if (!sel_valid) begin
          state_nxt = IDLE;
        end else if (sel_idx != cur_idx) begin
          cnt_nxt = '0;
          idx_nxt = sel_idx;
        end else if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = settle_cnt + SET_W'(1);
        end
      end
      HOLD: begin
        if (!sel_valid) begin
          state_nxt = IDLE;
        end else if (sel_idx != cur_idx) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
          idx_nxt   = sel_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign seg_on = ~data_s2[SEG_G:SEG_A];

  seg_char_decode u_char (
    .segs   (seg_on),
    .nibble (ch_nib),
    .blank  (ch_blank),
    .err    (ch_err)
  );

  always_comb begin
    sh_dig_nxt   = sh_dig;
    sh_dp_nxt    = sh_dp;
    sh_blank_nxt = sh_blank;
    sh_err_nxt   = sh_err;
    seen_nxt     = seen;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cur_idx == IDX_W'(i)) begin
        sh_dig_nxt[4*i +: 4] = ch_nib;
        sh_dp_nxt[i]         = ~data_s2[SEG_DP];
        sh_blank_nxt[i]      = ch_blank;
        sh_err_nxt[i]        = ch_err;
        seen_nxt[i]          = 1'b1;
      end
    end
  end

  always_comb begin
    if (capture)                                to_cnt_nxt = '0;
    else if (to_cnt == TO_W'(TIMEOUT_CYCLES))   to_cnt_nxt = to_cnt;
    else                                        to_cnt_nxt = to_cnt + TO_W'(1);
  end

  always_ff @(posedge CLK100MHZ or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      cur_idx     <= '0;
      sh_dig      <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      sh_err      <= '0;
      seen        <= '0;
      to_cnt      <= '0;
      digits      <= '0;
      dp          <= '0;
      blank       <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
      stale       <= 1'b0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= cnt_nxt;
      cur_idx     <= idx_nxt;
      to_cnt      <= to_cnt_nxt;
      stale       <= (to_cnt_nxt == TO_W'(TIMEOUT_CYCLES));
      frame_valid <= 1'b0;
      if (capture) begin
        sh_dig   <= sh_dig_nxt;
        sh_dp    <= sh_dp_nxt;
        sh_blank <= sh_blank_nxt;
        sh_err   <= sh_err_nxt;
        // Publish includes the digit being captured on this edge
        if (&seen_nxt) begin
          digits      <= sh_dig_nxt;
          dp          <= sh_dp_nxt;
          blank       <= sh_blank_nxt;
          err         <= sh_err_nxt;
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: stimulus pushes expected frames,
// a monitor pops and compares them on every frame_valid pulse.
module tb_seg_scan_decoder;

  logic        CLK100MHZ = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  seg_cs_pin = 8'hFF;
  logic [7:0]  seg_data_pin = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  dp, blank, err;
  logic        frame_valid, stale;

  typedef struct packed {
    logic [31:0] dig;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  err;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  int cyc = 0;
  int fv_cyc = 0;

  // Active-low pins, digit 7 in the top byte down to digit 0 in the bottom byte
  localparam logic [63:0] PINS_1TO8 = 64'hF9A4B099_9282F880;
  localparam logic [63:0] PINS_A0   = 64'h8888FF88_40888888;
  localparam logic [63:0] PINS_ERR  = 64'hF9A4B099_92B6F880;
  localparam logic [63:0] PINS_9TO0 = 64'h908883C6_A1868EC0;

  seg_scan_decoder #(
    .NUM_DIGITS     (8),
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .CLK100MHZ    (CLK100MHZ),
    .rst          (rst),
    .seg_cs_pin   (seg_cs_pin),
    .seg_data_pin (seg_data_pin),
    .digits       (digits),
    .dp           (dp),
    .blank        (blank),
    .err          (err),
    .frame_valid  (frame_valid),
    .stale        (stale)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expect_frame(input logic [31:0] d, input logic [7:0] p,
                              input logic [7:0] b, input logic [7:0] e);
    frame_t f;
    f.dig = d; f.dp = p; f.blank = b; f.err = e;
    exp_q.push_back(f);
  endtask

  task automatic scan_digit(input int d, input logic [7:0] pin, input int dwell);
    logic [7:0] cs;
    cs = 8'hFF;
    cs[d] = 1'b0;
    @(negedge CLK100MHZ);
    seg_cs_pin   = cs;
    seg_data_pin = pin;
    repeat (dwell - 1) @(negedge CLK100MHZ);
  endtask

  task automatic scan_frame(input logic [63:0] pins);
    for (int d = 7; d >= 0; d--) scan_digit(d, pins[8*d +: 8], 64);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_digits"}, digits, 32'h0);
    check({tag, "_dp"}, {24'h0, dp}, 32'h0);
    check({tag, "_blank"}, {24'h0, blank}, 32'h0);
    check({tag, "_err"}, {24'h0, err}, 32'h0);
    check({tag, "_frame_valid"}, {31'h0, frame_valid}, 32'h0);
    check({tag, "_stale"}, {31'h0, stale}, 32'h0);
  endtask

  // Monitor: every frame_valid cycle must match the oldest expected frame
  initial begin
    frame_t e;
    forever begin
      @(posedge CLK100MHZ);
      #1;
      if (frame_valid === 1'b1) begin
        frames_seen++;
        fv_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got frame %h expected none", digits);
        end else begin
          e = exp_q.pop_front();
          check("frame_digits", digits, e.dig);
          check("frame_dp", {24'h0, dp}, {24'h0, e.dp});
          check("frame_blank", {24'h0, blank}, {24'h0, e.blank});
          check("frame_err", {24'h0, err}, {24'h0, e.err});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    repeat (3) @(negedge CLK100MHZ);
    check_all_zero("reset");
    rst = 1'b1;

    expect_frame(32'h12345678, 8'h00, 8'h00, 8'h00);
    scan_frame(PINS_1TO8);

    expect_frame(32'hAA0A0AAA, 8'h08, 8'h20, 8'h00);
    scan_frame(PINS_A0);

    expect_frame(32'h12345078, 8'h00, 8'h00, 8'h04);
    scan_frame(PINS_ERR);
    check("frames_after_err", frames_seen, 3);

    // Digit 4 only glitches for 8 cycles, so the frame must not complete
    for (int d = 7; d >= 5; d--) scan_digit(d, PINS_9TO0[8*d +: 8], 64);
    scan_digit(4, 8'hF9, 8);
    scan_digit(5, PINS_9TO0[47:40], 64);
    for (int d = 3; d >= 0; d--) scan_digit(d, PINS_9TO0[8*d +: 8], 64);
    check("frames_after_glitch", frames_seen, 3);
    check("held_digits_glitch", digits, 32'h12345078);
    expect_frame(32'h9ABCDEF0, 8'h00, 8'h00, 8'h00);
    scan_digit(4, PINS_9TO0[39:32], 64);
    check("frames_after_digit4", frames_seen, 4);

    @(negedge CLK100MHZ);
    seg_cs_pin = 8'hFC;
    repeat (100) @(negedge CLK100MHZ);
    check("frames_after_multi_sel", frames_seen, 4);
    check("held_digits_multi_sel", digits, 32'h9ABCDEF0);
    check("held_err_multi_sel", {24'h0, err}, 32'h0);

    expect_frame(32'h12345678, 8'h00, 8'h00, 8'h00);
    scan_frame(PINS_1TO8);
    check("frames_after_resume", frames_seen, 5);

    // Digit 0 stays selected in HOLD, so the frame capture is the last one
    waited = 0;
    while (stale !== 1'b1 && waited < 1200) begin
      @(negedge CLK100MHZ);
      waited++;
    end
    check("stale_asserted", {31'h0, stale}, 32'h1);
    check("stale_delay", cyc - fv_cyc, 1000);
    check("digits_kept_when_stale", digits, 32'h12345678);

    for (int d = 7; d >= 5; d--) scan_digit(d, PINS_A0[8*d +: 8], 64);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge CLK100MHZ);
    rst = 1'b1;

    expect_frame(32'hAA0A0AAA, 8'h08, 8'h20, 8'h00);
    scan_frame(PINS_A0);
    check("frames_after_reset", frames_seen, 6);
    check("queue_drained", exp_q.size(), 0);

    repeat (10) @(negedge CLK100MHZ);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
